// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: one owner at a time, one-cycle GAP on release.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    output logic             timeout
);

    if (N_REQ < 2 || N_REQ > 16 || MAX_HOLD < 1) begin : g_cfg_err
        $error("rr_grant_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state;
    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] next_ptr;
    logic            found;
    int              scan_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int HC_W = $clog2(MAX_HOLD + 1);
    logic [HC_W-1:0] hold_cnt;
`endif

    // First requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        win      = ptr;
        found    = 1'b0;
        scan_idx = 0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_idx = (int'(ptr) + i) % N_REQ;
            if (!found && req[scan_idx]) begin
                found = 1'b1;
                win   = ID_W'(scan_idx);
            end
        end
    end

    // Pointer value after the current owner lets go.
    always_comb begin
        if (grant_id == ID_W'(N_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = grant_id + ID_W'(1);
        end
    end

    // Ownership FSM with registered grant outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            timeout     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
`endif
        end else begin
            timeout <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= GRANT;
                        grant       <= N_REQ'(1) << win;
                        grant_valid <= 1'b1;
                        grant_id    <= win;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt    <= HC_W'(1);
`endif
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        state       <= GAP;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        ptr         <= next_ptr;
`ifdef ARB_TIMEOUT_EN
                    end else if (hold_cnt == HC_W'(MAX_HOLD)) begin
                        state       <= GAP;
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        grant_id    <= '0;
                        ptr         <= next_ptr;
                        timeout     <= 1'b1;
                    end else begin
                        hold_cnt    <= hold_cnt + HC_W'(1);
`endif
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
